// File: rtl/block_stream_decrypter.sv
`default_nettype none
// ============================================================================
// Module   : block_stream_decrypter
// Brief    : Streams encrypted pixels through an external 64-bit block-cipher
//            core and writes the decrypted pixels to the frame buffer.
//            Define CBC_EN for CBC chaining; ECB otherwise.
// Revision : 1.0
// ============================================================================
module block_stream_decrypter #(
  parameter int PIX_W   = 8,
  parameter int BLK_PIX = 8,
  parameter int ADDR_W  = 15,
  parameter int NUM_PIX = 30625
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [63:0]       key,
  input  logic [63:0]       iv,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              wr_en,
  output logic [63:0]       core_msg,
  output logic [63:0]       core_key,
  output logic              core_en,
  input  logic              core_done,
  input  logic [63:0]       core_result,
  output logic              core_ack,
  output logic              busy,
  output logic              done
);

  localparam int                 c_cnt_w       = $clog2(BLK_PIX + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_fetch   = c_cnt_w'(BLK_PIX);
  localparam logic [c_cnt_w-1:0] c_cnt_drain   = c_cnt_w'(BLK_PIX - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one     = c_cnt_w'(1);
  localparam logic [ADDR_W:0]    c_num_pix     = (ADDR_W + 1)'(NUM_PIX);
  localparam logic [ADDR_W:0]    c_blk_pix     = (ADDR_W + 1)'(BLK_PIX);
  localparam logic [ADDR_W:0]    c_pos_one     = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0]  c_base_step   = ADDR_W'(BLK_PIX);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_ACK    = 3'd4,
    S_DRAIN  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_base;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [63:0]         r_msg;
  logic [63:0]         r_out;
  logic [63:0]         w_chain;
  logic [ADDR_W:0]     w_pos;
  logic [PIX_W-1:0]    w_pix_in;
  logic                w_last_blk;
  logic                w_drain_end;

  // Pixel position is one bit wider so the final partial block never wraps.
  assign w_pos       = {1'b0, r_base} + (ADDR_W + 1)'(r_cnt);
  // In FETCH cycle k the data belongs to address w_pos-1, valid if < NUM_PIX.
  assign w_pix_in    = (w_pos <= c_num_pix) ? rd_data : '0;
  assign w_last_blk  = ({1'b0, r_base} + c_blk_pix) >= c_num_pix;
  assign w_drain_end = (r_cnt == c_cnt_drain) || ((w_pos + c_pos_one) >= c_num_pix);

  assign core_msg = r_msg;
  assign core_key = key;

`ifdef CBC_EN
  logic [63:0] r_chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_chain <= '0;
    end else if ((r_state == S_IDLE || r_state == S_DONE) && start) begin
      r_chain <= iv;
    end else if (r_state == S_ACK) begin
      r_chain <= r_msg;
    end
  end

  assign w_chain = r_chain;
`else
  logic w_unused_iv;

  assign w_unused_iv = ^iv;
  assign w_chain     = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    core_en     = 1'b0;
    core_ack    = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    rd_addr     = '0;
    wr_addr     = '0;
    wr_data     = '0;
    wr_en       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = S_FETCH;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (r_cnt != c_cnt_fetch) begin
          rd_addr = w_pos[ADDR_W-1:0];
        end else begin
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        core_en     = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) w_state_nxt = S_ACK;
      end
      S_ACK: begin
        core_ack    = 1'b1;
        w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        wr_en   = (w_pos < c_num_pix);
        wr_addr = w_pos[ADDR_W-1:0];
        wr_data = r_out[63 -: PIX_W];
        if (w_drain_end) w_state_nxt = w_last_blk ? S_DONE : S_FETCH;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Slots are shifted in from the LSB end so slot 0 lands in the MSBs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base <= '0;
      r_cnt  <= '0;
      r_msg  <= '0;
      r_out  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_base <= '0;
            r_cnt  <= '0;
          end
        end
        S_FETCH: begin
          if (r_cnt != '0) r_msg <= (r_msg << PIX_W) | 64'(w_pix_in);
          r_cnt <= (r_cnt == c_cnt_fetch) ? '0 : r_cnt + c_cnt_one;
        end
        S_WAIT: begin
          if (core_done) r_out <= core_result ^ w_chain;
        end
        S_DRAIN: begin
          r_out <= r_out << PIX_W;
          if (w_drain_end) begin
            r_cnt <= '0;
            if (!w_last_blk) r_base <= r_base + c_base_step;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
